// File: rtl/selector_pkg.sv
// Shared constants and helpers for the multi-input selector register.
package selector_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  localparam int unsigned STALL_CNT_W = 16;

  // Index width for n channels, never narrower than one bit.
  function automatic int unsigned sel_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < n) w = 32'(i + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// Round-robin grant search: first requesting channel after ptr, wrapping modulo NUM_IN.
module rr_grant_picker
  import selector_pkg::*;
#(
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W  = sel_clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx_c,
  output logic              gnt_vld_c
);

  int unsigned cand;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    cand      = 0;
    for (int off = NUM_IN; off > 0; off--) begin
      cand = 32'(ptr) + 32'(off);
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      if (req[SEL_W'(cand)]) begin
        gnt_idx_c = SEL_W'(cand);
        gnt_vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_input_selector_reg.sv
// NUM_IN:1 valid/ready selector into a one-entry output register, explicit or round-robin.
// Optional stall counter port StallCount is enabled by defining SELECTOR_STALL_CNT_EN.
module multi_input_selector_reg
  import selector_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W  = sel_clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [NUM_IN*WIDTH-1:0] InData,
  input  logic [NUM_IN-1:0]       InValid,
  output logic [NUM_IN-1:0]       InReady,
  input  logic                    Mode,
  input  logic [SEL_W-1:0]        Control,
  output logic [WIDTH-1:0]        OutData,
  output logic [SEL_W-1:0]        OutSource,
  output logic                    OutValid,
  input  logic                    OutReady
`ifdef SELECTOR_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]  StallCount
`endif
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_vld_q, out_vld_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en_c;
  logic             exp_vld_c;
  logic [SEL_W-1:0] rr_idx_c;
  logic             rr_vld_c;
  logic [SEL_W-1:0] gnt_idx_c;
  logic             gnt_vld_c;
  logic             accept_c;
  logic [WIDTH-1:0] sel_data_c;

  rr_grant_picker #(
    .NUM_IN (NUM_IN)
  ) u_rr_grant_picker (
    .req       (InValid),
    .ptr       (rr_ptr_q),
    .gnt_idx_c (rr_idx_c),
    .gnt_vld_c (rr_vld_c)
  );

  // Explicit grant compares against each real channel, so an out-of-range Control never matches.
  always_comb begin
    exp_vld_c = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if ((Control == SEL_W'(i)) && InValid[i]) exp_vld_c = 1'b1;
    end
  end

  always_comb begin
    load_en_c = !out_vld_q || OutReady;
    gnt_idx_c = (Mode == MODE_RR) ? rr_idx_c : Control;
    gnt_vld_c = (Mode == MODE_RR) ? rr_vld_c : exp_vld_c;
    accept_c  = RST_n && load_en_c && gnt_vld_c;
  end

  always_comb begin
    InReady = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      InReady[i] = accept_c && (gnt_idx_c == SEL_W'(i));
    end
  end

  always_comb begin
    sel_data_c = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx_c == SEL_W'(i)) sel_data_c = InData[i*WIDTH +: WIDTH];
    end
  end

  // Output register next state; data and source hold when the register drains empty.
  always_comb begin
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    out_vld_d  = out_vld_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept_c) begin
      out_data_d = sel_data_c;
      out_src_d  = gnt_idx_c;
      out_vld_d  = 1'b1;
      if (Mode == MODE_RR) rr_ptr_d = gnt_idx_c;
    end else if (OutReady) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      out_data_q <= '0;
      out_src_q  <= '0;
      out_vld_q  <= 1'b0;
      rr_ptr_q   <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      out_vld_q  <= out_vld_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign OutData   = out_data_q;
  assign OutSource = out_src_q;
  assign OutValid  = out_vld_q;

`ifdef SELECTOR_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the consumer holds a valid word back.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_vld_q && !OutReady && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multi_input_selector_reg.sv
// Directed bench for multi_input_selector_reg: 4-channel DUT plus a 3-channel DUT for out-of-range Control.
module tb_multi_input_selector_reg;

  logic clk;
  logic rst_n;

  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid;
  logic [3:0]   a_in_ready;
  logic         a_mode;
  logic [1:0]   a_ctrl;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_src;
  logic         a_out_vld;
  logic         a_out_rdy;

  logic [95:0]  b_in_data;
  logic [2:0]   b_in_valid;
  logic [2:0]   b_in_ready;
  logic         b_mode;
  logic [1:0]   b_ctrl;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_src;
  logic         b_out_vld;
  logic         b_out_rdy;

`ifdef SELECTOR_STALL_CNT_EN
  logic [15:0]  a_stall;
  logic [15:0]  b_stall;
`endif

  int tests;
  int fails;

  multi_input_selector_reg #(.WIDTH(32), .NUM_IN(4)) u_dut_a (
    .CLK       (clk),
    .RST_n     (rst_n),
    .InData    (a_in_data),
    .InValid   (a_in_valid),
    .InReady   (a_in_ready),
    .Mode      (a_mode),
    .Control   (a_ctrl),
    .OutData   (a_out_data),
    .OutSource (a_out_src),
    .OutValid  (a_out_vld),
    .OutReady  (a_out_rdy)
`ifdef SELECTOR_STALL_CNT_EN
    ,
    .StallCount(a_stall)
`endif
  );

  multi_input_selector_reg #(.WIDTH(32), .NUM_IN(3)) u_dut_b (
    .CLK       (clk),
    .RST_n     (rst_n),
    .InData    (b_in_data),
    .InValid   (b_in_valid),
    .InReady   (b_in_ready),
    .Mode      (b_mode),
    .Control   (b_ctrl),
    .OutData   (b_out_data),
    .OutSource (b_out_src),
    .OutValid  (b_out_vld),
    .OutReady  (b_out_rdy)
`ifdef SELECTOR_STALL_CNT_EN
    ,
    .StallCount(b_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] rr_data [5];
  logic [1:0]  rr_src  [5];
  logic [3:0]  rr_rdy  [5];

  initial begin
    tests = 0;
    fails = 0;
    rr_data = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003, 32'h1111_0000};
    rr_src  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    a_in_data  = {32'h4444_0003, 32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
    b_in_data  = {32'hB222_2222, 32'hB111_1111, 32'hB000_0000};
    rst_n      = 1'b0;
    a_in_valid = 4'b1111;
    a_mode     = 1'b1;
    a_ctrl     = 2'd0;
    a_out_rdy  = 1'b1;
    b_in_valid = 3'b111;
    b_mode     = 1'b0;
    b_ctrl     = 2'd0;
    b_out_rdy  = 1'b1;

    // Reset held for two edges with every channel valid
    tick();
    tick();
    check("rst_out_valid",  64'(a_out_vld),  64'h0);
    check("rst_out_data",   64'(a_out_data), 64'h0);
    check("rst_out_source", 64'(a_out_src),  64'h0);
    check("rst_in_ready",   64'(a_in_ready), 64'h0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'h0);
    b_in_valid = 3'b000;

    // Round-robin from reset: 0,1,2,3,0 back to back
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("rr_in_ready_%0d", k), 64'(a_in_ready), 64'(rr_rdy[k]));
      tick();
      check($sformatf("rr_out_source_%0d", k), 64'(a_out_src),  64'(rr_src[k]));
      check($sformatf("rr_out_data_%0d", k),   64'(a_out_data), 64'(rr_data[k]));
      check($sformatf("rr_out_valid_%0d", k),  64'(a_out_vld),  64'h1);
    end

    // Explicit select of channel 2
    a_mode = 1'b0;
    a_ctrl = 2'd2;
    settle();
    check("exp_in_ready", 64'(a_in_ready), 64'b0100);
    tick();
    check("exp_out_data",   64'(a_out_data), 64'hDEAD_BEEF);
    check("exp_out_source", 64'(a_out_src),  64'h2);
    check("exp_out_valid",  64'(a_out_vld),  64'h1);

    // Backpressure: held word stays put while Control moves
    a_out_rdy = 1'b0;
    a_ctrl    = 2'd1;
    settle();
    check("bp_in_ready_pre", 64'(a_in_ready), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_out_data_%0d", k),   64'(a_out_data), 64'hDEAD_BEEF);
      check($sformatf("bp_out_source_%0d", k), 64'(a_out_src),  64'h2);
      check($sformatf("bp_out_valid_%0d", k),  64'(a_out_vld),  64'h1);
      check($sformatf("bp_in_ready_%0d", k),   64'(a_in_ready), 64'h0);
    end

    // Release with channel 1 only: same-cycle refill
    a_mode     = 1'b1;
    a_in_valid = 4'b0010;
    a_out_rdy  = 1'b1;
    settle();
    check("refill_in_ready", 64'(a_in_ready), 64'b0010);
    tick();
    check("refill_out_source", 64'(a_out_src),  64'h1);
    check("refill_out_data",   64'(a_out_data), 64'h2222_0001);
    check("refill_out_valid",  64'(a_out_vld),  64'h1);

    // Nothing valid: register drains, data/source hold
    a_in_valid = 4'b0000;
    settle();
    check("drain_in_ready", 64'(a_in_ready), 64'h0);
    tick();
    check("drain_out_valid",  64'(a_out_vld),  64'h0);
    check("drain_out_source", 64'(a_out_src),  64'h1);
    check("drain_out_data",   64'(a_out_data), 64'h2222_0001);

    // Pointer at 1 with channels 0 and 3 valid: 3 first, then wrap to 0
    a_in_valid = 4'b1001;
    settle();
    check("wrap_in_ready_a", 64'(a_in_ready), 64'b1000);
    tick();
    check("wrap_out_source_a", 64'(a_out_src), 64'h3);
    settle();
    check("wrap_in_ready_b", 64'(a_in_ready), 64'b0001);
    tick();
    check("wrap_out_source_b", 64'(a_out_src),  64'h0);
    check("wrap_out_data_b",   64'(a_out_data), 64'h1111_0000);

    // Three-channel DUT: in-range Control, then Control=3
    b_ctrl     = 2'd1;
    b_in_valid = 3'b111;
    settle();
    check("oor_b_in_ready_ok", 64'(b_in_ready), 64'b010);
    tick();
    check("oor_b_out_valid_ok",  64'(b_out_vld),  64'h1);
    check("oor_b_out_source_ok", 64'(b_out_src),  64'h1);
    check("oor_b_out_data_ok",   64'(b_out_data), 64'hB111_1111);
    b_ctrl = 2'd3;
    settle();
    check("oor_b_in_ready", 64'(b_in_ready), 64'h0);
    tick();
    check("oor_b_out_valid",  64'(b_out_vld),  64'h0);
    check("oor_b_out_source", 64'(b_out_src),  64'h1);
    check("oor_b_out_data",   64'(b_out_data), 64'hB111_1111);

`ifdef SELECTOR_STALL_CNT_EN
    // Three earlier stall cycles, three more here, then saturate
    a_in_valid = 4'b0000;
    a_out_rdy  = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("stall_count_6", 64'(a_stall), 64'h6);
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    check("stall_count_sat", 64'(a_stall), 64'hFFFF);
    tick();
    check("stall_count_hold", 64'(a_stall), 64'hFFFF);
`endif

    // Reset while a word is held and backpressured
    a_in_valid = 4'b1111;
    a_out_rdy  = 1'b0;
    rst_n      = 1'b0;
    settle();
    check("mid_rst_in_ready", 64'(a_in_ready), 64'h0);
    tick();
    check("mid_rst_out_valid",  64'(a_out_vld),  64'h0);
    check("mid_rst_out_data",   64'(a_out_data), 64'h0);
    check("mid_rst_out_source", 64'(a_out_src),  64'h0);
`ifdef SELECTOR_STALL_CNT_EN
    check("mid_rst_stall", 64'(a_stall), 64'h0);
`endif
    rst_n     = 1'b1;
    a_mode    = 1'b1;
    a_out_rdy = 1'b1;
    settle();
    check("post_rst_in_ready", 64'(a_in_ready), 64'b0001);
    tick();
    check("post_rst_out_source", 64'(a_out_src),  64'h0);
    check("post_rst_out_data",   64'(a_out_data), 64'h1111_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
